// File: rtl/amc_operand_stager_if.sv
// Operand/result bundle between the bench or producer and the stager.
// Carries operand push, datapath drive/return and result handshake.
interface amc_operand_stager_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] a_o;
  logic [3:0] b_o;
  logic [7:0] res_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;

  modport master (
    output in_valid, in_a, in_b,
    output res_i, out_ready,
    input  in_ready, a_o, b_o,
    input  out_valid, out_result
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  res_i, out_ready,
    output in_ready, a_o, b_o,
    output out_valid, out_result
  );
endinterface

// File: rtl/amc_operand_stager.sv
// Operand stager: FIFO of operand pairs, settle window, result capture.
// Ports: clk, rst (async high), bus (slave: operand push, a_o/b_o drive,
// res_i return, out_valid/out_ready result), txn_count when the macro
// AMC_STAGER_TXN_COUNT_EN is defined.
module amc_operand_stager #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst,
  amc_operand_stager_if.slave bus
`ifdef AMC_STAGER_TXN_COUNT_EN
  ,
  output logic [15:0] txn_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(SETTLE) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic [7:0]    res_q;
  logic          vld_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          hs;
  logic          take;
  logic [7:0]    head;

  assign full  = (wptr[AW-1:0] == rptr[AW-1:0])
              && (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

  // in_ready ignores a same-cycle pop: a full FIFO never accepts.
  assign bus.in_ready = !full && !rst;
  assign push = bus.in_valid && bus.in_ready;

  assign hs   = (state == HOLD) && bus.out_ready;
  assign take = !empty && ((state == IDLE) || hs);

  assign bus.a_o        = a_q;
  assign bus.b_o        = b_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_result = res_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
    end else if (push) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rptr  <= '0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      // Popping a pair is identical from IDLE and from HOLD.
      if (take) begin
        rptr <= rptr + 1'b1;
        a_q  <= head[7:4];
        b_q  <= head[3:0];
        cnt  <= CW'(SETTLE - 1);
      end
      unique case (state)
        IDLE: begin
          if (!empty) state <= ISSUE;
        end
        ISSUE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res_q <= bus.res_i;
            vld_q <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            state <= empty ? IDLE : ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AMC_STAGER_TXN_COUNT_EN
  logic [15:0] txn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q <= '0;
    end else if (hs) begin
      txn_q <= txn_q + 16'd1;
    end
  end

  assign txn_count = txn_q;
`endif

endmodule

// File: tb/tb_amc_operand_stager.sv
// Self-checking bench for amc_operand_stager.
// Transaction model of the FIFO/settle timing plus directed checks.
module tb_amc_operand_stager;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  amc_operand_stager_if intf ();

`ifdef AMC_STAGER_TXN_COUNT_EN
  logic [15:0] txn_count;
`endif

  amc_operand_stager #(
    .DEPTH (DEPTH),
    .SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
`ifdef AMC_STAGER_TXN_COUNT_EN
    ,
    .txn_count(txn_count)
`endif
  );

  always #5 clk = ~clk;

  assign intf.res_i = {intf.a_o, intf.b_o};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         t;
  } pair_t;

  pair_t       pend [$];
  bit          busy  = 1'b0;
  int          iss_t = 0;
  int          e     = 0;
  logic [3:0]  ea    = '0;
  logic [3:0]  eb    = '0;
  logic [7:0]  eres  = '0;
  bit          ev    = 1'b0;
  logic [15:0] m_txn = '0;

  // Model: pairs wait in a queue; the stage takes the oldest one at
  // the first edge after it arrived and after the previous result
  // was accepted, holds it SETTLE edges, then offers the result.
  initial begin
    pair_t p;
    bit    acc;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pend.delete();
        busy  = 1'b0;
        ea    = '0;
        eb    = '0;
        eres  = '0;
        ev    = 1'b0;
        m_txn = '0;
      end else begin
        e++;
        acc = intf.in_valid && (pend.size() < DEPTH);
        if (busy && e > iss_t + SETTLE && intf.out_ready) begin
          busy = 1'b0;
          m_txn++;
        end
        if (!busy && pend.size() > 0 && pend[0].t < e) begin
          p     = pend.pop_front();
          ea    = p.a;
          eb    = p.b;
          iss_t = e;
          busy  = 1'b1;
        end
        if (acc) begin
          p.a = intf.in_a;
          p.b = intf.in_b;
          p.t = e;
          pend.push_back(p);
        end
        ev = busy && (e >= iss_t + SETTLE);
        if (ev) eres = {ea, eb};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 16'(intf.in_ready),
          16'(!rst && pend.size() < DEPTH));
      chk("out_valid", 16'(intf.out_valid), 16'(ev));
      chk("a_o", 16'(intf.a_o), 16'(ea));
      chk("b_o", 16'(intf.b_o), 16'(eb));
      if (ev) chk("out_result", 16'(intf.out_result), 16'(eres));
`ifdef AMC_STAGER_TXN_COUNT_EN
      chk("txn_count", txn_count, m_txn);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20; n++) begin
      if (intf.out_valid) return;
      step();
    end
    chk("wait_valid_timeout", 16'(intf.out_valid), 16'd1);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      intf.in_valid = 1'b1;
      intf.in_a     = 4'(base + i);
      intf.in_b     = 4'(base + i);
      step();
    end
    intf.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    intf.out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [7:0] got [$];
  int         times [$];
  logic [7:0] full_exp [5];

  initial begin
    bit acc;
    int k;
    full_exp[0] = 8'h11;
    full_exp[1] = 8'h22;
    full_exp[2] = 8'h33;
    full_exp[3] = 8'h44;
    full_exp[4] = 8'h55;

    intf.in_valid  = 1'b0;
    intf.in_a      = '0;
    intf.in_b      = '0;
    intf.out_ready = 1'b0;
    rst            = 1'b1;
    step();
    step();
    chk("rst_in_ready", 16'(intf.in_ready), 16'd0);
    chk("rst_out_valid", 16'(intf.out_valid), 16'd0);
    chk("rst_a_o", 16'(intf.a_o), 16'd0);
    chk("rst_b_o", 16'(intf.b_o), 16'd0);
    chk("rst_out_result", 16'(intf.out_result), 16'd0);
    rst = 1'b0;

    // single pair
    intf.out_ready = 1'b1;
    intf.in_valid  = 1'b1;
    intf.in_a      = 4'd3;
    intf.in_b      = 4'd5;
    step();
    intf.in_valid = 1'b0;
    step();
    chk("single_a_o", 16'(intf.a_o), 16'd3);
    chk("single_b_o", 16'(intf.b_o), 16'd5);
    chk("single_early_valid", 16'(intf.out_valid), 16'd0);
    step();
    step();
    chk("single_valid", 16'(intf.out_valid), 16'd1);
    chk("single_result", 16'(intf.out_result), 16'h35);
    step();
    chk("single_done", 16'(intf.out_valid), 16'd0);
    drain(4);

    // full FIFO and refused pair
    intf.out_ready = 1'b0;
    push_n(6, 1);
    chk("full_in_ready", 16'(intf.in_ready), 16'd0);
    chk("full_stage_a", 16'(intf.a_o), 16'd1);
    intf.out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 30; i++) begin
      if (intf.out_valid) got.push_back(intf.out_result);
      step();
    end
    chk("full_count", 16'(got.size()), 16'd5);
    for (int i = 0; i < got.size() && i < 5; i++) begin
      chk("full_order", 16'(got[i]), 16'(full_exp[i]));
    end

    // back-to-back stream of 8
    intf.out_ready = 1'b1;
    times.delete();
    k = 0;
    for (int c = 0; c < 80; c++) begin
      if (k < 8) begin
        intf.in_valid = 1'b1;
        intf.in_a     = 4'($urandom);
        intf.in_b     = 4'($urandom);
      end else begin
        intf.in_valid = 1'b0;
      end
      acc = intf.in_valid && intf.in_ready;
      step();
      if (acc) k++;
      if (intf.out_valid) times.push_back(c);
    end
    chk("b2b_count", 16'(times.size()), 16'd8);
    for (int i = 1; i < times.size(); i++) begin
      chk("b2b_gap", 16'(times[i] - times[i-1]),
          16'(SETTLE + 1));
    end

    // push and pop in the same cycle
    intf.out_ready = 1'b0;
    push_n(4, 6);
    wait_valid();
    intf.in_valid  = 1'b1;
    intf.in_a      = 4'hA;
    intf.in_b      = 4'hB;
    intf.out_ready = 1'b1;
    step();
    intf.in_valid  = 1'b0;
    intf.out_ready = 1'b0;
    chk("pp_in_ready", 16'(intf.in_ready), 16'd1);
    push_n(1, 12);
    chk("pp_full", 16'(intf.in_ready), 16'd0);
    drain(30);

    // reset while a pair is in ISSUE with 3 buffered
    intf.out_ready = 1'b0;
    push_n(5, 1);
    wait_valid();
    intf.out_ready = 1'b1;
    step();
    intf.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(intf.out_valid), 16'd0);
    chk("mid_rst_ready", 16'(intf.in_ready), 16'd0);
    chk("mid_rst_a_o", 16'(intf.a_o), 16'd0);
    step();
    rst = 1'b0;
    intf.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_valid", 16'(intf.out_valid), 16'd0);
    end
    chk("post_rst_ready", 16'(intf.in_ready), 16'd1);

`ifdef AMC_STAGER_TXN_COUNT_EN
    push_n(3, 2);
    drain(20);
    chk("txn_three", txn_count, 16'd3);
    force dut.txn_q = 16'hFFFF;
    m_txn = 16'hFFFF;
    #1;
    release dut.txn_q;
    push_n(1, 4);
    drain(10);
    chk("txn_wrap", txn_count, 16'd0);
`endif

    // random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      intf.in_valid  = 1'($urandom);
      intf.in_a      = 4'($urandom);
      intf.in_b      = 4'($urandom);
      intf.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    intf.in_valid = 1'b0;
    drain(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
